// File: rtl/alu_seq_if.sv
// Handshake and result bundle between an operand source and alu_seq.
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             ovf;
    logic             zero;
    logic             neg;
    logic             busy;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, result, carry, ovf, zero, neg, busy
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, result, carry, ovf, zero, neg, busy
    );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU with handshake: add/sub/logic ops plus bit-serial variable shifts.
// Latency: 1 cycle for non-shift ops and zero-amount shifts, N+1 cycles for an N-bit shift.
// Backpressure: result holds in HOLD until out_ready; in_ready only in IDLE, so ops never overlap.
module alu_seq #(
    parameter int WIDTH     = 8,
    parameter bit ARITH_SHR = 1'b0
) (
    input  logic      clk,
    input  logic      rst,
    alu_seq_if.slave  io
);
    localparam int SHW = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_NOT = 3'b111;

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic             shr_q, shr_d;

    logic [WIDTH:0]   sum, diff;
    logic [WIDTH-1:0] alu_res, sh_res;
    logic             alu_c, alu_o, sh_c;
    logic [SHW-1:0]   amt;
    logic             is_shift;

    // Single-cycle datapath, evaluated on the live inputs at the accept edge.
    always_comb begin
        sum      = {1'b0, io.a} + {1'b0, io.b};
        diff     = {1'b0, io.a} - {1'b0, io.b};
        amt      = io.b[SHW-1:0];
        is_shift = (io.op == OP_SHL) || (io.op == OP_SHR);
        alu_res  = '0;
        alu_c    = 1'b0;
        alu_o    = 1'b0;
        case (io.op)
            OP_ADD: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_o   = (io.a[MSB] == io.b[MSB]) && (sum[MSB] != io.a[MSB]);
            end
            OP_SUB: begin
                alu_res = diff[WIDTH-1:0];
                alu_c   = diff[WIDTH];
                alu_o   = (io.a[MSB] != io.b[MSB]) && (diff[MSB] != io.a[MSB]);
            end
            OP_AND:  alu_res = io.a & io.b;
            OP_OR:   alu_res = io.a | io.b;
            OP_XOR:  alu_res = io.a ^ io.b;
            OP_SHL:  alu_res = io.a;
            OP_SHR:  alu_res = io.a;
            OP_NOT:  alu_res = ~io.a;
            default: alu_res = '0;
        endcase
    end

    // One bit of shift per SHIFT cycle; carry tracks the bit just dropped.
    always_comb begin
        if (shr_q) begin
            sh_c   = res_q[0];
            sh_res = {ARITH_SHR & res_q[MSB], res_q[WIDTH-1:1]};
        end else begin
            sh_c   = res_q[MSB];
            sh_res = {res_q[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        neg_d   = neg_q;
        cnt_d   = cnt_q;
        shr_d   = shr_q;
        case (state_q)
            IDLE: begin
                if (io.in_valid) begin
                    if (is_shift && (amt != '0)) begin
                        state_d = SHIFT;
                        res_d   = io.a;
                        cnt_d   = amt;
                        shr_d   = (io.op == OP_SHR);
                        carry_d = 1'b0;
                        ovf_d   = 1'b0;
                        zero_d  = 1'b0;
                        neg_d   = 1'b0;
                    end else begin
                        state_d = HOLD;
                        res_d   = alu_res;
                        carry_d = alu_c;
                        ovf_d   = alu_o;
                        zero_d  = (alu_res == '0);
                        neg_d   = alu_res[MSB];
                    end
                end
            end
            SHIFT: begin
                res_d   = sh_res;
                carry_d = sh_c;
                cnt_d   = cnt_q - 1'b1;
                if (cnt_q == SHW'(1)) begin
                    state_d = HOLD;
                    zero_d  = (sh_res == '0);
                    neg_d   = sh_res[MSB];
                end
            end
            HOLD: begin
                if (io.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            res_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            cnt_q   <= '0;
            shr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
            cnt_q   <= cnt_d;
            shr_q   <= shr_d;
        end
    end

    assign io.in_ready  = (state_q == IDLE) && !rst;
    assign io.out_valid = (state_q == HOLD);
    assign io.busy      = (state_q != IDLE);
    assign io.result    = res_q;
    assign io.carry     = carry_q;
    assign io.ovf       = ovf_q;
    assign io.zero      = zero_q;
    assign io.neg       = neg_q;
endmodule
